mult_shift_add: RTL

Sequential unsigned shift-and-add multiplier. It is the multiplication counterpart of the restoring-division A/Q datapath and shares the same C/A/Q register organisation, with the shift direction reversed (right). A control FSM and a datapath compute a 2N-bit product over N add/shift iterations. A start/busy/done handshake connects it to the arithmetic unit top level.

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_shift_add_caq.sv | 51 +++++
 rtl/mult_shift_add.sv | 98 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mult_pkg;
    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        SHIFT,
        DONE
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_w(N_DEF);
endpackage

// File: rtl/mult_shift_add_caq.sv
// C/A/Q datapath register: load, add, then right shift in priority order.
module reg_caq
    import mult_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         add,
    input  logic         shift,
    input  logic [N-1:0] m,
    input  logic [N-1:0] q_in,
    output logic [N-1:0] a,
    output logic [N-1:0] q
);
    logic         c_d, c_q;
    logic [N-1:0] a_d, a_q;
    logic [N-1:0] q_d, q_q;

    always_comb begin
        c_d = c_q;
        a_d = a_q;
        q_d = q_q;
        if (load) begin
            c_d = 1'b0;
            a_d = '0;
            q_d = q_in;
        end else if (add) begin
            {c_d, a_d} = {1'b0, a_q} + {1'b0, m};
        end else if (shift) begin
            // 2N+1-bit logical right shift, zero into C
            {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_q <= 1'b0;
            a_q <= '0;
            q_q <= '0;
        end else begin
            c_q <= c_d;
            a_q <= a_d;
            q_q <= q_d;
        end
    end

    assign a = a_q;
    assign q = q_q;
endmodule

// File: rtl/mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier: FSM, counter, product register.
module mult_shift_add
    import mult_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicando,
    input  logic [N-1:0]   multiplicador,
    output logic [2*N-1:0] produto,
    output logic           busy,
    output logic           done
);
    localparam int CW = cnt_w(N);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    m_q, m_d;
    logic [2*N-1:0]  produto_q, produto_d;
    logic            done_q, done_d;
    logic            load, add, shift;
    logic [N-1:0]    a, q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_q       <= '0;
            produto_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            produto_q <= produto_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = TEST;
            TEST:    state_d = SHIFT;
            SHIFT:   state_d = (cnt_q == CW'(1)) ? DONE : TEST;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        add       = 1'b0;
        shift     = 1'b0;
        cnt_d     = cnt_q;
        m_d       = m_q;
        produto_d = produto_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load  = 1'b1;
                    m_d   = multiplicando;
                    cnt_d = CW'(N);
                end
            end
            TEST:  add = q[0];
            SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q - CW'(1);
            end
            DONE: begin
                // A/Q already hold the post-shift product here
                produto_d = {a, q};
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    reg_caq #(.N(N)) u_caq (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .add   (add),
        .shift (shift),
        .m     (m_q),
        .q_in  (multiplicador),
        .a     (a),
        .q     (q)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign produto = produto_q;
endmodule
